// File: rtl/dual_issue_regfile.sv
// -----------------------------------------------------------------------------
// dual_issue_regfile
//
// Architectural register file for the dual-issue core. It takes the two MEM/WB
// write streams (slot 0 and slot 1) every cycle and serves four combinational
// read ports to decode. Writes landing this cycle are forwarded straight to the
// read ports, so decode never sees a stale value. A registered flag reports
// when both slots wrote the same non-zero register in the previous cycle.
//
// Ports:
//   clk                   rising-edge clock for all state
//   reset                 asynchronous, active-low; clears every entry and the flag
//   RegWriteEn_inst0_WB   slot-0 write enable
//   dest_reg_inst0_WB     slot-0 destination index
//   writeData_inst0_WB    slot-0 write data
//   RegWriteEn_inst1_WB   slot-1 write enable (younger instruction)
//   dest_reg_inst1_WB     slot-1 destination index
//   writeData_inst1_WB    slot-1 write data
//   rs1_inst0/rs2_inst0   read indices for slot 0
//   rs1_inst1/rs2_inst1   read indices for slot 1
//   rd1_inst0/rd2_inst0   read data for slot 0 (combinational, bypassed)
//   rd1_inst1/rd2_inst1   read data for slot 1 (combinational, bypassed)
//   wr_collision          registered: both slots wrote the same non-zero index
// -----------------------------------------------------------------------------
module dual_issue_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWriteEn_inst0_WB,
  input  logic [ADDR_WIDTH-1:0] dest_reg_inst0_WB,
  input  logic [DATA_WIDTH-1:0] writeData_inst0_WB,
  input  logic                  RegWriteEn_inst1_WB,
  input  logic [ADDR_WIDTH-1:0] dest_reg_inst1_WB,
  input  logic [DATA_WIDTH-1:0] writeData_inst1_WB,
  input  logic [ADDR_WIDTH-1:0] rs1_inst0,
  input  logic [ADDR_WIDTH-1:0] rs2_inst0,
  input  logic [ADDR_WIDTH-1:0] rs1_inst1,
  input  logic [ADDR_WIDTH-1:0] rs2_inst1,
  output logic [DATA_WIDTH-1:0] rd1_inst0,
  output logic [DATA_WIDTH-1:0] rd2_inst0,
  output logic [DATA_WIDTH-1:0] rd1_inst1,
  output logic [DATA_WIDTH-1:0] rd2_inst1,
  output logic                  wr_collision
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  wr_collision_q;
  logic                  wr_collision_d;
  logic                  wen0_s;
  logic                  wen1_s;

  // Read-port value: x0 is hardwired zero, then the younger slot-1 write wins
  // over slot 0, then the stored entry.
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [ADDR_WIDTH-1:0] idx,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  we0,
    input logic [ADDR_WIDTH-1:0] wa0,
    input logic [DATA_WIDTH-1:0] wd0,
    input logic                  we1,
    input logic [ADDR_WIDTH-1:0] wa1,
    input logic [DATA_WIDTH-1:0] wd1
  );
    logic [DATA_WIDTH-1:0] val;
    if (idx == {ADDR_WIDTH{1'b0}}) begin
      val = {DATA_WIDTH{1'b0}};
    end else if (we1 && (wa1 == idx)) begin
      val = wd1;
    end else if (we0 && (wa0 == idx)) begin
      val = wd0;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Write qualification: an enabled write to x0 is treated as no write at all.
  always_comb begin
    wen0_s = RegWriteEn_inst0_WB && (dest_reg_inst0_WB != {ADDR_WIDTH{1'b0}});
    wen1_s = RegWriteEn_inst1_WB && (dest_reg_inst1_WB != {ADDR_WIDTH{1'b0}});
  end

  // Next register-file contents; slot 1 overrides slot 0 on a shared index.
  always_comb begin
    regs_d[0] = {DATA_WIDTH{1'b0}};
    for (int i = 1; i < DEPTH; i++) begin
      if (wen1_s && (dest_reg_inst1_WB == i[ADDR_WIDTH-1:0])) begin
        regs_d[i] = writeData_inst1_WB;
      end else if (wen0_s && (dest_reg_inst0_WB == i[ADDR_WIDTH-1:0])) begin
        regs_d[i] = writeData_inst0_WB;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Collision is only meaningful between two qualified (non-zero) writes.
  always_comb begin
    wr_collision_d = wen0_s && wen1_s && (dest_reg_inst0_WB == dest_reg_inst1_WB);
  end

  // State registers: storage array and collision flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
      wr_collision_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_collision_q <= wr_collision_d;
    end
  end

  // Four identical bypassed read ports.
  always_comb begin
    rd1_inst0 = read_port(rs1_inst0, regs_q[rs1_inst0], wen0_s, dest_reg_inst0_WB,
                          writeData_inst0_WB, wen1_s, dest_reg_inst1_WB, writeData_inst1_WB);
    rd2_inst0 = read_port(rs2_inst0, regs_q[rs2_inst0], wen0_s, dest_reg_inst0_WB,
                          writeData_inst0_WB, wen1_s, dest_reg_inst1_WB, writeData_inst1_WB);
    rd1_inst1 = read_port(rs1_inst1, regs_q[rs1_inst1], wen0_s, dest_reg_inst0_WB,
                          writeData_inst0_WB, wen1_s, dest_reg_inst1_WB, writeData_inst1_WB);
    rd2_inst1 = read_port(rs2_inst1, regs_q[rs2_inst1], wen0_s, dest_reg_inst0_WB,
                          writeData_inst0_WB, wen1_s, dest_reg_inst1_WB, writeData_inst1_WB);
  end

  assign wr_collision = wr_collision_q;

endmodule

// File: tb/tb_dual_issue_regfile.sv
// -----------------------------------------------------------------------------
// tb_dual_issue_regfile: directed, self-checking bench for dual_issue_regfile.
// -----------------------------------------------------------------------------
module tb_dual_issue_regfile;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic          we0;
  logic [AW-1:0] wa0;
  logic [DW-1:0] wd0;
  logic          we1;
  logic [AW-1:0] wa1;
  logic [DW-1:0] wd1;
  logic [AW-1:0] ra1_0;
  logic [AW-1:0] ra2_0;
  logic [AW-1:0] ra1_1;
  logic [AW-1:0] ra2_1;
  logic [DW-1:0] rd1_0;
  logic [DW-1:0] rd2_0;
  logic [DW-1:0] rd1_1;
  logic [DW-1:0] rd2_1;
  logic          coll;

  int n_cmp;
  int n_bad;

  dual_issue_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .RegWriteEn_inst0_WB (we0),
    .dest_reg_inst0_WB   (wa0),
    .writeData_inst0_WB  (wd0),
    .RegWriteEn_inst1_WB (we1),
    .dest_reg_inst1_WB   (wa1),
    .writeData_inst1_WB  (wd1),
    .rs1_inst0           (ra1_0),
    .rs2_inst0           (ra2_0),
    .rs1_inst1           (ra1_1),
    .rs2_inst1           (ra2_1),
    .rd1_inst0           (rd1_0),
    .rd2_inst0           (rd2_0),
    .rd1_inst1           (rd1_1),
    .rd2_inst1           (rd2_1),
    .wr_collision        (coll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic set_wr(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    we0 = e0; wa0 = a0; wd0 = d0;
    we1 = e1; wa1 = a1; wd1 = d1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [AW-1:0] c, input logic [AW-1:0] d);
    ra1_0 = a; ra2_0 = b; ra1_1 = c; ra2_1 = d;
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // Reset held with writes (and a would-be collision) driven at x5.
    reset = 1'b0;
    set_wr(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 32'hDEADBEEF);
    set_rd(5'd1, 5'd2, 5'd6, 5'd0);
    tick();
    tick();
    check("rst_rd1_0", rd1_0, 32'h0);
    check("rst_rd2_0", rd2_0, 32'h0);
    check("rst_rd1_1", rd1_1, 32'h0);
    check("rst_rd2_1", rd2_1, 32'h0);
    check("rst_coll", {31'b0, coll}, 32'h0);

    // Release reset, no writes: x5 must not have been written during reset.
    reset = 1'b1;
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_rd(5'd5, 5'd5, 5'd5, 5'd5);
    #1;
    check("rel_x5_same", rd1_0, 32'h0);
    tick();
    check("rel_x5_next", rd2_1, 32'h0);
    check("rel_coll", {31'b0, coll}, 32'h0);

    // Dual write to different indices, visible via bypass then storage.
    set_wr(1'b1, 5'd3, 32'h11111111, 1'b1, 5'd4, 32'h22222222);
    set_rd(5'd3, 5'd4, 5'd4, 5'd3);
    #1;
    check("dual_byp_rd1_0", rd1_0, 32'h11111111);
    check("dual_byp_rd2_0", rd2_0, 32'h22222222);
    check("dual_byp_rd1_1", rd1_1, 32'h22222222);
    tick();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check("dual_st_rd1_0", rd1_0, 32'h11111111);
    check("dual_st_rd2_0", rd2_0, 32'h22222222);
    check("dual_st_rd2_1", rd2_1, 32'h11111111);
    check("dual_coll", {31'b0, coll}, 32'h0);

    // Same-index collision on x7: slot 1 wins, flag pulses for one cycle.
    set_wr(1'b1, 5'd7, 32'hAAAA0000, 1'b1, 5'd7, 32'h0000BBBB);
    set_rd(5'd7, 5'd3, 5'd7, 5'd4);
    #1;
    check("coll_byp_rd1_0", rd1_0, 32'h0000BBBB);
    check("coll_byp_rd1_1", rd1_1, 32'h0000BBBB);
    check("coll_pre_flag", {31'b0, coll}, 32'h0);
    tick();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check("coll_st_x7", rd1_0, 32'h0000BBBB);
    check("coll_flag_hi", {31'b0, coll}, 32'h1);
    tick();
    check("coll_flag_lo", {31'b0, coll}, 32'h0);
    check("coll_st_x7_b", rd1_1, 32'h0000BBBB);

    // Both slots write x0: reads stay 0 and no collision is flagged.
    set_wr(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF);
    set_rd(5'd0, 5'd0, 5'd0, 5'd0);
    #1;
    check("x0_same_rd1_0", rd1_0, 32'h0);
    check("x0_same_rd2_1", rd2_1, 32'h0);
    tick();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check("x0_next_rd2_0", rd2_0, 32'h0);
    check("x0_coll", {31'b0, coll}, 32'h0);

    // Disabled writes to x9 leave it untouched and do not bypass.
    set_wr(1'b0, 5'd9, 32'h12345678, 1'b0, 5'd9, 32'h12345678);
    set_rd(5'd9, 5'd9, 5'd9, 5'd9);
    #1;
    check("dis_same_x9", rd2_1, 32'h0);
    tick();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check("dis_next_x9", rd1_0, 32'h0);

    // Slot-0 only write, then back-to-back overwrite of the same index.
    set_wr(1'b1, 5'd12, 32'h00000001, 1'b0, 5'd12, 32'hCAFECAFE);
    set_rd(5'd12, 5'd12, 5'd12, 5'd12);
    #1;
    check("s0only_byp_x12", rd1_1, 32'h00000001);
    tick();
    set_wr(1'b1, 5'd12, 32'h00000002, 1'b0, 5'd0, 32'h0);
    #1;
    check("b2b_byp_x12", rd2_0, 32'h00000002);
    tick();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check("b2b_st_x12", rd1_0, 32'h00000002);

    // Four-port read: preload x1..x4 with 1..4, then slot 1 writes x3=0x33.
    set_wr(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    tick();
    set_wr(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4);
    tick();
    set_wr(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33);
    set_rd(5'd1, 5'd2, 5'd3, 5'd4);
    #1;
    check("four_rd1_0", rd1_0, 32'h1);
    check("four_rd2_0", rd2_0, 32'h2);
    check("four_rd1_1", rd1_1, 32'h33);
    check("four_rd2_1", rd2_1, 32'h4);
    tick();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check("four_st_x3", rd1_1, 32'h33);

    // Collision then asynchronous reset mid-cycle: flag and storage clear at once.
    set_wr(1'b1, 5'd20, 32'h01010101, 1'b1, 5'd20, 32'h02020202);
    tick();
    set_wr(1'b1, 5'd21, 32'h55555555, 1'b0, 5'd0, 32'h0);
    set_rd(5'd3, 5'd20, 5'd1, 5'd4);
    #1;
    check("pre_rst_coll", {31'b0, coll}, 32'h1);
    check("pre_rst_x20", rd2_0, 32'h02020202);
    reset = 1'b0;
    #1;
    check("arst_coll", {31'b0, coll}, 32'h0);
    check("arst_x3", rd1_0, 32'h0);
    check("arst_x20", rd2_0, 32'h0);
    tick();
    reset = 1'b1;
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_rd(5'd21, 5'd4, 5'd1, 5'd2);
    #1;
    check("arst_x21_lost", rd1_0, 32'h0);
    check("arst_x4", rd2_0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dual_issue_regfile.md
# dual_issue_regfile

Architectural register file for the dual-issue core, sitting at the far end of both writeback paths. It accepts the two MEM/WB write streams (slot 0 and slot 1) every cycle and serves four combinational read ports to the decode stage (rs1/rs2 for each slot). Same-cycle writeback-to-decode bypass is provided internally, so decode never sees a stale value for a register being written in the current cycle. A registered collision flag reports when both slots target the same non-zero register.

## Interface
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low
- RegWriteEn_inst0_WB  input  1  slot-0 write enable
- dest_reg_inst0_WB  input  ADDR_WIDTH  slot-0 destination index
- writeData_inst0_WB  input  DATA_WIDTH  slot-0 write data
- RegWriteEn_inst1_WB  input  1  slot-1 write enable
- dest_reg_inst1_WB  input  ADDR_WIDTH  slot-1 destination index
- writeData_inst1_WB  input  DATA_WIDTH  slot-1 write data
- rs1_inst0, rs2_inst0, rs1_inst1, rs2_inst1  input  ADDR_WIDTH each  read indices from decode
- rd1_inst0, rd2_inst0, rd1_inst1, rd2_inst1  output  DATA_WIDTH each  read data (combinational)
- wr_collision  output  1  registered: both slots wrote the same non-zero index last cycle

## Operation
- Storage: 2**ADDR_WIDTH entries of DATA_WIDTH bits; entry 0 not writable, always reads 0.
- Write qualification: slot n writes iff RegWriteEn_instn_WB=1 and dest_reg_instn_WB!=0.
- Dual write: both qualified writes to different indices commit in the same edge.
- Same-index collision: slot 1 is the younger instruction in program order; its data wins. Slot-0 data for that index is discarded.
- Read port value, evaluated per port, in priority order:
  - index 0 -> 0.
  - index matches qualified slot-1 write this cycle -> writeData_inst1_WB.
  - index matches qualified slot-0 write this cycle -> writeData_inst0_WB.
  - otherwise -> stored entry.
- Bypass applies identically to all four read ports; reads never depend on the decode slot.
- wr_collision: set on edge when both slots qualified and dest indices equal; cleared on the next edge otherwise. Write to index 0 by both slots does not set it.
- Enable low with any dest/data: no state change, no bypass.

## Timing
- Reset (reset=0, asynchronous): all entries cleared to 0, wr_collision=0 immediately; all read outputs then 0 combinationally (bypass still active if enables asserted during reset, but no entry is written while reset=0).
- Reset release: first write commits on first rising edge with reset=1.
- Write latency: committed on rising edge; visible via bypass in the same cycle, via storage from the next cycle onward.
- Read latency: 0 cycles (purely combinational from index and current write inputs).
- wr_collision: 1-cycle latency after the colliding write cycle; high exactly one cycle per collision.
- Reset asserted mid-stream: in-flight writes of that edge are lost; no partial entry update.
- Back-to-back writes to same index across cycles: the later cycle's value overwrites; reads in the later cycle see the later value.

## Test plan
- Reset: hold reset=0 with enables driven, writes to x5=0xDEADBEEF -> all reads 0, wr_collision=0; release, next cycle x5 still 0.
- Dual write: slot0 x3=0x11111111, slot1 x4=0x22222222 -> same cycle rd1_inst0(rs1=x3)=0x11111111 via bypass; next cycle rs1=x3, rs2=x4 read 0x11111111/0x22222222.
- Collision: both slots write x7 (slot0 0xAAAA0000, slot1 0x0000BBBB) -> same-cycle read x7=0x0000BBBB; next cycle stored x7=0x0000BBBB, wr_collision=1; following cycle wr_collision=0.
- x0 protection: both slots write x0=0xFFFFFFFF -> all reads of x0=0 same and next cycle, wr_collision stays 0.
- Disabled write: enables 0, dest=x9, data=0x12345678 -> x9 reads prior value (0) same and next cycle.
- Four-port read: preload x1..x4 with 1..4, set rs1_inst0=x1, rs2_inst0=x2, rs1_inst1=x3, rs2_inst1=x4 while slot1 writes x3=0x33 -> outputs 1, 2, 0x33, 4.
